mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers, replacing the single-cycle combinational mult/div path of the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX through a start/busy/done handshake. The pipeline stalls on `busy` and reads `hi`/`lo` directly for MFHI/MFLO.

---
 rtl/mdu_iter_if.sv | 26 ++
 rtl/mdu_iter.sv | 180 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: EX <-> MDU request/response bundle.
// master = EX stage side, slave = multiply/divide unit.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/DIV unit owning HI/LO.
// Optional MDU_FAST_MUL_EN: one-shot registered multiplier.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  mdu_iter_if.slave   m
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             div_q, div_d;
  logic             negp_q, negp_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dzo_q, dzo_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   msum;
  logic [W2-1:0]    mul_step;
  logic [WIDTH:0]   dsh;
  logic [WIDTH:0]   ddif;
  logic [W2-1:0]    div_step;
  logic [W2-1:0]    pneg;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
`ifdef MDU_FAST_MUL_EN
  logic [W2-1:0]    fast_p;
`endif

  // Operand magnitudes and one datapath step.
  // prod_q is {acc, multiplier} or {rem, dividend}.
  always_comb begin
    a_neg = ~m.op[0] & m.a[WIDTH-1];
    b_neg = ~m.op[0] & m.b[WIDTH-1];
    a_mag = a_neg ? -m.a : m.a;
    b_mag = b_neg ? -m.b : m.b;
    msum  = {1'b0, prod_q[W2-1:WIDTH]}
          + (prod_q[0] ? {1'b0, opb_q}
                       : {(WIDTH+1){1'b0}});
    mul_step = {msum, prod_q[WIDTH-1:1]};
    dsh   = {prod_q[W2-1:WIDTH], prod_q[WIDTH-1]};
    ddif  = dsh - {1'b0, opb_q};
    div_step = ddif[WIDTH]
      ? {dsh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
      : {ddif[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    pneg  = -prod_q;
    rem   = prod_q[W2-1:WIDTH];
    quo   = prod_q[WIDTH-1:0];
`ifdef MDU_FAST_MUL_EN
    fast_p = {{WIDTH{1'b0}}, a_mag}
           * {{WIDTH{1'b0}}, b_mag};
`endif
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    opb_d   = opb_q;
    div_d   = div_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dzo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m.start && !m.op[2]) begin
          div_d   = m.op[1];
          negp_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          dz_d    = m.op[1] && (m.b == '0);
          opb_d   = b_mag;
          cnt_d   = '0;
          prod_d  = {{WIDTH{1'b0}}, a_mag};
          state_d = CALC;
`ifdef MDU_FAST_MUL_EN
          if (!m.op[1]) begin
            prod_d  = fast_p;
            state_d = FIX;
          end
`endif
        end else if (m.start && !m.op[1]) begin
          if (m.op[0]) lo_d = m.a;
          else         hi_d = m.a;
        end
      end
      CALC: begin
        prod_d = div_q ? div_step : mul_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1))
          state_d = FIX;
      end
      FIX: begin
        if (div_q) begin
          hi_d = negr_q ? -rem : rem;
          lo_d = dz_q   ? '1
               : negp_q ? -quo : quo;
        end else begin
          {hi_d, lo_d} = negp_q ? pneg : prod_q;
        end
        done_d  = 1'b1;
        dzo_d   = dz_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    if (m.flush) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      dzo_d   = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State, datapath and HI/LO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      opb_q   <= opb_d;
      div_q   <= div_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dzo_q   <= dzo_d;
    end
  end

  assign m.busy     = busy_q;
  assign m.done     = done_q;
  assign m.div_zero = dzo_q;
  assign m.hi       = hi_q;
  assign m.lo       = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed checks of mdu_iter.
// Expected values are hand-computed constants.
module tb_mdu_iter;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MLAT = 2;
`else
  localparam int MLAT = 34;
`endif

  logic clk;
  logic rst;
  int   passed;
  int   total;
  int   lat;
  logic seen;

  mdu_iter_if #(.WIDTH(W)) m ();

  mdu_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .m   (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s got=%h want=%h",
                tag, obs, exp);
  endtask

  task automatic issue(
    input logic [2:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    m.start = 1'b1;
    m.op    = op;
    m.a     = a;
    m.b     = b;
    @(posedge clk);
    #1;
    m.start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    logic hit;
    hit = 1'b0;
    l   = -1;
    for (int i = 1; i <= 100; i++) begin
      if (!hit) begin
        @(posedge clk);
        #1;
        if (m.done) begin
          hit = 1'b1;
          l   = i;
        end
      end
    end
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    rst     = 1'b0;
    m.start = 1'b0;
    m.op    = 3'd0;
    m.a     = '0;
    m.b     = '0;
    m.flush = 1'b0;
    #2;
    chk("rst_busy", 64'(m.busy), 64'd0);
    chk("rst_done", 64'(m.done), 64'd0);
    chk("rst_dz", 64'(m.div_zero), 64'd0);
    chk("rst_hi", 64'(m.hi), 64'd0);
    chk("rst_lo", 64'(m.lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // MULT -2 * 3
    issue(3'b000, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy", 64'(m.busy), 64'd1);
    wait_done(lat);
    chk("mult_lat", 64'(lat + 1), 64'(MLAT));
    chk("mult_hi", 64'(m.hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(m.lo), 64'hFFFF_FFFA);
    chk("mult_busy0", 64'(m.busy), 64'd0);
    @(negedge clk);

    // MULTU max*max, then back-to-back DIVU
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat);
    chk("multu_lat", 64'(lat + 1), 64'(MLAT));
    chk("multu_hi", 64'(m.hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(m.lo), 64'h0000_0001);
    issue(3'b011, 32'd100, 32'd7);
    chk("b2b_busy", 64'(m.busy), 64'd1);
    chk("b2b_done", 64'(m.done), 64'd0);
    wait_done(lat);
    chk("divu_lat", 64'(lat + 1), 64'd34);
    chk("divu_hi", 64'(m.hi), 64'd2);
    chk("divu_lo", 64'(m.lo), 64'd14);
    @(negedge clk);

    // DIV -7 / 2
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    chk("div_lo", 64'(m.lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(m.hi), 64'hFFFF_FFFF);
    chk("div_dz", 64'(m.div_zero), 64'd0);
    @(negedge clk);

    // DIV overflow
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    chk("ovf_lo", 64'(m.lo), 64'h8000_0000);
    chk("ovf_hi", 64'(m.hi), 64'd0);
    chk("ovf_dz", 64'(m.div_zero), 64'd0);
    @(negedge clk);

    // DIVU by zero
    issue(3'b011, 32'd7, 32'd0);
    wait_done(lat);
    chk("dzu_lo", 64'(m.lo), 64'hFFFF_FFFF);
    chk("dzu_hi", 64'(m.hi), 64'd7);
    chk("dzu_dz", 64'(m.div_zero), 64'd1);
    @(posedge clk);
    #1;
    chk("dzu_done0", 64'(m.done), 64'd0);
    chk("dzu_dz0", 64'(m.div_zero), 64'd0);
    @(negedge clk);

    // DIV 7 / -2
    issue(3'b010, 32'd7, 32'hFFFF_FFFE);
    wait_done(lat);
    chk("divn_lo", 64'(m.lo), 64'hFFFF_FFFD);
    chk("divn_hi", 64'(m.hi), 64'd1);
    @(negedge clk);

    // DIV -5 by zero
    issue(3'b010, 32'hFFFF_FFFB, 32'd0);
    wait_done(lat);
    chk("dzs_lo", 64'(m.lo), 64'hFFFF_FFFF);
    chk("dzs_hi", 64'(m.hi), 64'hFFFF_FFFB);
    chk("dzs_dz", 64'(m.div_zero), 64'd1);
    @(negedge clk);

    // MTLO / MTHI
    issue(3'b101, 32'h1234, 32'd0);
    chk("mtlo_lo", 64'(m.lo), 64'h1234);
    chk("mtlo_hi", 64'(m.hi), 64'hFFFF_FFFB);
    chk("mtlo_done", 64'(m.done), 64'd0);
    chk("mtlo_busy", 64'(m.busy), 64'd0);
    @(negedge clk);
    issue(3'b100, 32'hABCD, 32'd0);
    chk("mthi_hi", 64'(m.hi), 64'hABCD);
    @(negedge clk);

    // flush beats start
    m.flush = 1'b1;
    issue(3'b100, 32'h5555, 32'd0);
    m.flush = 1'b0;
    chk("fls_hi", 64'(m.hi), 64'hABCD);
    chk("fls_busy", 64'(m.busy), 64'd0);
    @(negedge clk);

    // flush mid DIVU
    issue(3'b011, 32'd50, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    m.flush = 1'b1;
    @(posedge clk);
    #1;
    m.flush = 1'b0;
    chk("flm_busy", 64'(m.busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (m.done || m.busy) seen = 1'b1;
    end
    chk("flm_quiet", 64'(seen), 64'd0);
    chk("flm_hi", 64'(m.hi), 64'hABCD);
    chk("flm_lo", 64'(m.lo), 64'h1234);
    @(negedge clk);

    // reset mid DIVU
    issue(3'b011, 32'd50, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rmo_hi", 64'(m.hi), 64'd0);
    chk("rmo_lo", 64'(m.lo), 64'd0);
    chk("rmo_busy", 64'(m.busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
